// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
package bp_pkg;

  // Tags are stored zero-extended to the widest tag any legal configuration
  // can take (32 PC bits minus the 2 byte-offset bits).
  localparam int BP_TAG_MAX = 30;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bp_cnt_t;

  typedef struct packed {
    logic                  valid;
    logic [BP_TAG_MAX-1:0] tag;
    logic [31:0]           target;
  } btb_entry_t;

  // Next 2-bit counter value: saturating step for conditional branches,
  // forced strongly-taken for unconditional jumps.
  function automatic bp_cnt_t bp_cnt_next(bp_cnt_t cnt, logic taken, logic is_cond);
    bp_cnt_t nxt;
    nxt = cnt;
    if (!is_cond) begin
      nxt = ST;
    end else if (taken) begin
      if (cnt != ST) nxt = bp_cnt_t'(cnt + 2'd1);
    end else begin
      if (cnt != SNT) nxt = bp_cnt_t'(cnt - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped BHT (2-bit counters) plus BTB. Predicts combinationally for
// fetch, learns from execute-stage resolutions, and emits registered
// mispredict/control-transfer pulses and a fetch redirect.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [31:0] fetchPc,
  output logic        predTaken,
  output logic [31:0] predTarget,
  input  logic        resValid,
  input  logic [31:0] resPc,
  input  logic        resIsCond,
  input  logic        resTaken,
  input  logic [31:0] resTarget,
  input  logic        resPredTaken,
  input  logic [31:0] resPredTarget,
  output logic        wrongBranch,
  output logic        controlXfer,
  output logic        redirect,
  output logic [31:0] redirectPc
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [BP_TAG_MAX-1:0] TAG_MASK = BP_TAG_MAX'((64'd1 << TAG_W) - 64'd1);

  // Tag is the TAG_W PC bits directly above the index field.
  function automatic logic [BP_TAG_MAX-1:0] tag_of(logic [31:0] pc);
    return BP_TAG_MAX'(pc >> (IDX_W + 2)) & TAG_MASK;
  endfunction

  btb_entry_t btb_q [ENTRIES];
  bp_cnt_t    cnt_q [ENTRIES];

  logic                  wrong_branch_q;
  logic                  control_xfer_q;
  logic                  redirect_q;
  logic [31:0]           redirect_pc_q;

  logic [IDX_W-1:0]      fetch_idx;
  logic                  fetch_hit;
  logic [IDX_W-1:0]      res_idx;
  logic [BP_TAG_MAX-1:0] res_tag;
  logic                  res_hit;
  bp_cnt_t               res_base;
  bp_cnt_t               res_cnt_d;
  logic                  res_mis;
  logic [31:0]           redirect_pc_d;

  assign fetch_idx = fetchPc[IDX_W+1:2];
  assign res_idx   = resPc[IDX_W+1:2];
  assign res_tag   = tag_of(resPc);

  // Prediction reads the registered tables, so a same-cycle update is not seen.
  always_comb begin
    fetch_hit  = btb_q[fetch_idx].valid && (btb_q[fetch_idx].tag == tag_of(fetchPc));
    predTaken  = fetch_hit && ((cnt_q[fetch_idx] == WT) || (cnt_q[fetch_idx] == ST));
    predTarget = predTaken ? btb_q[fetch_idx].target : (fetchPc + 32'd4);
  end

  // Resolution: a freshly allocated entry starts from WT (branch) or ST (jump)
  // and then takes the normal counter step.
  always_comb begin
    res_hit       = btb_q[res_idx].valid && (btb_q[res_idx].tag == res_tag);
    res_base      = res_hit ? cnt_q[res_idx] : (resIsCond ? WT : ST);
    res_cnt_d     = bp_cnt_next(res_base, resTaken, resIsCond);
    res_mis       = resValid &&
                    ((resTaken != resPredTaken) ||
                     (resTaken && (resTarget != resPredTarget)));
    redirect_pc_d = resTaken ? resTarget : (resPc + 32'd4);
  end

  // Table update: taken outcomes (re)write the BTB entry; a not-taken miss
  // leaves everything alone.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '0;
        cnt_q[i] <= WNT;
      end
    end else if (resValid && (resTaken || res_hit)) begin
      cnt_q[res_idx] <= res_cnt_d;
      if (resTaken) begin
        btb_q[res_idx] <= '{valid: 1'b1, tag: res_tag, target: resTarget};
      end
    end
  end

  // One-cycle event pulses and redirect, registered one cycle after resValid.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrong_branch_q <= 1'b0;
      control_xfer_q <= 1'b0;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= 32'd0;
    end else begin
      wrong_branch_q <= res_mis;
      control_xfer_q <= resValid;
      redirect_q     <= res_mis;
      if (resValid) redirect_pc_q <= redirect_pc_d;
    end
  end

  assign wrongBranch = wrong_branch_q;
  assign controlXfer = control_xfer_q;
  assign redirect    = redirect_q;
  assign redirectPc  = redirect_pc_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor with a direct-mapped branch history table (2-bit saturating counters) and branch target buffer, updated from the execute-stage branch resolution. It supplies taken/target predictions to fetch. On each resolution it raises the single-cycle `wrongBranch` and `controlXfer` event pulses consumed by the performance-counter CSR file, plus a redirect to fetch on mispredict.

## Interface
- `ENTRIES`, 16: table depth; power of two, ≥2; index = `IDX_W = $clog2(ENTRIES)`.
- `TAG_W`, 8: BTB tag width taken from PC bits above the index.
- `clk` input 1: clock, all state on rising edge.
- `rstN` input 1: asynchronous, active-low reset.
- `fetchPc` input 32: PC being fetched this cycle.
- `predTaken` output 1: combinational prediction for `fetchPc`.
- `predTarget` output 32: predicted target; equals `fetchPc + 4` when `predTaken`=0.
- `resValid` input 1: execute presents a resolved control-transfer instruction this cycle.
- `resPc` input 32: PC of the resolved instruction.
- `resIsCond` input 1: 1 = conditional branch, 0 = unconditional jump (jal/jalr).
- `resTaken` input 1: actual outcome (forced 1 by execute for jumps).
- `resTarget` input 32: actual target address.
- `resPredTaken` input 1: prediction that travelled down the pipe with this instruction.
- `resPredTarget` input 32: predicted target that travelled with it.
- `wrongBranch` output 1: registered one-cycle pulse, mispredict resolved.
- `controlXfer` output 1: registered one-cycle pulse, any control transfer resolved.
- `redirect` output 1: registered one-cycle pulse to fetch, equal to `wrongBranch`.
- `redirectPc` output 32: correct next PC, valid while `redirect`=1.

## Operation
- Index = `pc[IDX_W+1:2]`; tag = `pc[IDX_W+TAG_W+1:IDX_W+2]`.
- Prediction: hit = `valid[idx]` && tag match. `predTaken` = hit && counter ≥ 2 (WT/ST). `predTarget` = `btbTarget[idx]` if `predTaken`, else `fetchPc+4`.
- Mispredict (`mis`) = `resValid` && (`resTaken != resPredTaken` || (`resTaken` && `resTarget != resPredTarget`)).
- Counter update on `resValid`:
  - Conditional: increment if taken, decrement if not.
  - Saturates at 0 (SNT) and 3 (ST).
  - Unconditional: counter set to ST.
- BTB update on `resValid && resTaken`: write valid=1, tag, and `resTarget`. This overwrites any aliased entry and resets its counter to WT, or to ST for jumps, before the update rule applies.
- Not-taken resolution with a BTB miss allocates nothing and leaves the counter untouched.
- `redirectPc` = `resTarget` if `resTaken`, else `resPc + 4`. Arithmetic is modulo 2^32, so it wraps at 0xFFFFFFFC.

## Timing
- Prediction is combinational from `fetchPc` and current table state, with zero cycle latency.
- Update writes on the rising edge of the cycle where `resValid`=1.
- `wrongBranch`, `controlXfer`, `redirect` and `redirectPc` are registered and assert exactly one cycle after `resValid`. Each pulse lasts one cycle per resolution. Back-to-back `resValid` produces back-to-back pulses.
- Same-index predict and update in the same cycle: the prediction uses the pre-update (old) state. The new state is visible from the next cycle.
- Reset values:
  - All valid bits 0; all counters WNT (1); BTB targets and tags 0.
  - `wrongBranch`=`controlXfer`=`redirect`=0; `redirectPc`=0.
- Reset asserted mid-operation: state clears immediately and any pending pulse is dropped. The first prediction after release is `predTaken`=0.

## Structure
- Shared package `bp_pkg`:
  - `bp_cnt_t`, a 2-bit enum SNT=0/WNT=1/WT=2/ST=3.
  - `btb_entry_t` struct {valid, tag, target}.
  - Function `bp_cnt_next(cnt, taken, isCond)` implementing saturation.
- No sub-module. Tables are plain arrays in this module, with async reset on valid and counter bits.

## Test plan
- Reset, then `fetchPc`=0x100 → `predTaken`=0, `predTarget`=0x104; all output pulses 0.
- Resolve cond branch at 0x100: taken, target 0x200, predicted not-taken → next cycle `wrongBranch`=`controlXfer`=`redirect`=1, `redirectPc`=0x200. Following fetch of 0x100 → `predTaken`=1, `predTarget`=0x200.
- Four not-taken resolutions at 0x100 → counter reaches SNT and holds at 0 (no underflow); `predTaken`=0. Then two taken resolutions are needed before `predTaken`=1.
- Aliasing: a taken branch at 0x140 with ENTRIES=16 (same index, different tag) evicts 0x100 → fetch 0x100 misses, `predTaken`=0.
- Correctly predicted jump (0x300→0x80, pred taken to 0x80) → `controlXfer`=1, `wrongBranch`=0. Resolving a taken branch at 0xFFFFFFFC as not-taken with pred taken gives `redirectPc`=0x0.
- Update and predict the same index in one cycle → old prediction observed. Assert `rstN` low during a resolve → no pulse next cycle and all entries invalid.
